// File: rtl/mem_bus_pkg.sv
// Shared definitions for the MAR/MDR memory bus controller.
// Parameter defaults, state encoding and wait-counter width.
package mem_bus_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 9;
  localparam int MEM_DEPTH_DEF = 512;
  localparam int RD_LAT_DEF    = 1;

  // Wide enough for the largest legal read latency minus one.
  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_CAP,
    ST_WR,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mem_bus_ctrl_wait_counter.sv
// Down-counter that paces the read wait window.
// Load has priority over decrement; the count saturates at zero.
module mem_wait_counter
  import mem_bus_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// MAR/MDR memory bus controller: sequences single-word RAM reads
// and writes with a configurable read latency and range checking.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int RD_LATENCY = RD_LAT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [ADDR_W-1:0] mar_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              addr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_M1 =
    CNT_W'(RD_LATENCY - 1);
  localparam logic [ADDR_W:0] DEPTH =
    (ADDR_W + 1)'(MEM_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic oor;

  assign oor = ({1'b0, mar_q} >= DEPTH);

  mem_wait_counter u_wait (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_M1),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    mar_d    = mar_q;
    mdr_d    = mdr_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    if (mar_in && !busy_q) begin
      mar_d = bus_in[ADDR_W-1:0];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (mdr_in && !rd_req) begin
          mdr_d = bus_in;
        end
        // Read wins over a same-cycle write.
        if (rd_req || wr_req) begin
          err_d = oor;
          if (oor) begin
            state_d = ST_DONE;
          end else if (rd_req) begin
            cnt_load = 1'b1;
            state_d  = ST_RD_WAIT;
          end else begin
            state_d = ST_WR;
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_RD_CAP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RD_CAP: begin
        mdr_d   = mem_rdata;
        state_d = ST_DONE;
      end
      ST_WR: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d  = (state_d == ST_RD_WAIT) ||
              (state_d == ST_RD_CAP) ||
              (state_d == ST_WR);
    done_d  = (state_d == ST_DONE);
    rd_en_d = (state_d == ST_RD_WAIT);
    wr_en_d = (state_d == ST_WR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
    end
  end

  assign mar_out   = mar_q;
  assign mdr_out   = mdr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign addr_err  = err_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mem_rd_en = rd_en_q;
  assign mem_wr_en = wr_en_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed table, corner sequences and
// random transactions against a transaction-level memory model.
module tb_mem_bus_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int DEPTH = 256;
  localparam int RL    = 3;
  localparam int WORDS = 512;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] bus_in = '0;
  logic          mar_in = 1'b0;
  logic          mdr_in = 1'b0;
  logic          rd_req = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] mar_out;
  logic [DW-1:0] mdr_out;
  logic          busy;
  logic          done;
  logic          addr_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [DW-1:0] mem_rdata = '0;
  logic          ram_init = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_bus_ctrl #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .MEM_DEPTH  (DEPTH),
    .RD_LATENCY (RL)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus_in    (bus_in),
    .mar_in    (mar_in),
    .mdr_in    (mdr_in),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .mar_out   (mar_out),
    .mdr_out   (mdr_out),
    .busy      (busy),
    .done      (done),
    .addr_err  (addr_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [DW-1:0] pat(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Synchronous RAM attached to the controller.
  logic [DW-1:0] ram [WORDS];
  always @(posedge clock) begin
    if (ram_init) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= pat(i);
    end else if (mem_wr_en) begin
      ram[mem_addr] <= mem_wdata;
    end
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  // Transaction-level model of what the memory and registers hold.
  logic [DW-1:0] m_mem [WORDS];
  logic [DW-1:0] m_mdr = '0;
  bit            m_err = 1'b0;

  function automatic void model_step(
    input bit rd, input bit wr,
    input logic [AW-1:0] addr, input logic [DW-1:0] data,
    output int lat, output bit err,
    output int rdc, output int wrc, output logic [DW-1:0] mdr);
    bit bad;
    bad = (int'(addr) >= DEPTH);
    lat = 0; rdc = 0; wrc = 0;
    if (wr && !rd) m_mdr = data;
    if (rd || wr) m_err = bad;
    if (bad) begin
      lat = 1;
    end else if (rd) begin
      lat = RL + 2;
      rdc = RL;
      m_mdr = m_mem[addr];
    end else begin
      lat = 2;
      wrc = 1;
      m_mem[addr] = data;
    end
    err = m_err;
    mdr = m_mdr;
  endfunction

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int            lat;
    bit            err;
    int            rdc;
    int            wrc;
    logic [DW-1:0] mdr;
    bit            wr_ok;
    bit            mar_ok;
  } obs_t;

  task automatic run_txn(input bit rd, input bit wr,
                         input logic [AW-1:0] addr,
                         input logic [DW-1:0] data,
                         output obs_t o);
    o = '{lat: 0, err: 0, rdc: 0, wrc: 0,
          mdr: '0, wr_ok: 1, mar_ok: 0};
    @(negedge clock);
    bus_in = DW'(addr);
    mar_in = 1'b1;
    @(negedge clock);
    mar_in = 1'b0;
    o.mar_ok = (mar_out == addr);
    if (wr && !rd) begin
      bus_in = data;
      mdr_in = 1'b1;
      @(negedge clock);
      mdr_in = 1'b0;
    end
    rd_req = rd;
    wr_req = wr;
    @(negedge clock);
    rd_req = 1'b0;
    wr_req = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_rd_en) o.rdc++;
      if (mem_wr_en) begin
        o.wrc++;
        if (mem_addr !== addr || mem_wdata !== data) o.wr_ok = 0;
      end
      if (done) begin
        o.lat = c;
        o.err = addr_err;
        o.mdr = mdr_out;
        break;
      end
      @(negedge clock);
    end
  endtask

  typedef struct {
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            lat;
    bit            err;
    int            rdc;
    int            wrc;
    logic [DW-1:0] mdr;
  } vec_t;

  vec_t vt [10];

  task automatic cmp_obs(input string tag, input obs_t o,
                         input int lat, input bit err,
                         input int rdc, input int wrc,
                         input logic [DW-1:0] mdr);
    chk({tag, "_mar"}, DW'(o.mar_ok), 1);
    chk({tag, "_lat"}, DW'(o.lat), DW'(lat));
    chk({tag, "_err"}, DW'(o.err), DW'(err));
    chk({tag, "_rdcyc"}, DW'(o.rdc), DW'(rdc));
    chk({tag, "_wrcyc"}, DW'(o.wrc), DW'(wrc));
    chk({tag, "_mdr"}, o.mdr, mdr);
    if (wrc > 0) chk({tag, "_wrbus"}, DW'(o.wr_ok), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    obs_t          o;
    int            lat, rdc, wrc, c;
    bit            err, rd, wr;
    logic [DW-1:0] mdr, d;
    logic [AW-1:0] a;

    for (int i = 0; i < WORDS; i++) m_mem[i] = pat(i);

    vt[0] = '{0, 1, 9'h010, 32'hDEADBEEF, 2, 0, 0, 1, 32'hDEADBEEF};
    vt[1] = '{0, 1, 9'h010, 32'h12345678, 2, 0, 0, 1, 32'h12345678};
    vt[2] = '{0, 1, 9'h011, 32'hA5A5A5A5, 2, 0, 0, 1, 32'hA5A5A5A5};
    vt[3] = '{1, 0, 9'h010, 32'h0,        5, 0, 3, 0, 32'h12345678};
    vt[4] = '{1, 0, 9'h1F0, 32'h0,        1, 1, 0, 0, 32'h12345678};
    vt[5] = '{0, 1, 9'h020, 32'h0BADF00D, 2, 0, 0, 1, 32'h0BADF00D};
    vt[6] = '{1, 1, 9'h011, 32'h0,        5, 0, 3, 0, 32'hA5A5A5A5};
    vt[7] = '{0, 1, 9'h100, 32'h11111111, 1, 1, 0, 0, 32'h11111111};
    vt[8] = '{0, 1, 9'h0FF, 32'hCAFEF00D, 2, 0, 0, 1, 32'hCAFEF00D};
    vt[9] = '{1, 0, 9'h0FF, 32'h0,        5, 0, 3, 0, 32'hCAFEF00D};

    // Reset state.
    @(negedge clock);
    @(negedge clock);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_done", DW'(done), 0);
    chk("rst_err", DW'(addr_err), 0);
    chk("rst_rden", DW'(mem_rd_en), 0);
    chk("rst_wren", DW'(mem_wr_en), 0);
    chk("rst_mar", DW'(mar_out), 0);
    chk("rst_mdr", mdr_out, 0);
    reset = 1'b0;
    ram_init = 1'b0;

    foreach (vt[i]) begin
      run_txn(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].data, o);
      model_step(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].data,
                 lat, err, rdc, wrc, mdr);
      cmp_obs($sformatf("vec%0d", i), o, vt[i].lat, vt[i].err,
              vt[i].rdc, vt[i].wrc, vt[i].mdr);
    end

    // MAR/MDR/wr_req pokes while a read is in its wait window.
    @(negedge clock);
    bus_in = 32'h020;
    mar_in = 1'b1;
    @(negedge clock);
    mar_in = 1'b0;
    rd_req = 1'b1;
    @(negedge clock);
    rd_req = 1'b0;
    bus_in = 32'h055;
    mar_in = 1'b1;
    mdr_in = 1'b1;
    wr_req = 1'b1;
    @(negedge clock);
    mar_in = 1'b0;
    mdr_in = 1'b0;
    wr_req = 1'b0;
    chk("poke_mar", DW'(mar_out), 32'h020);
    chk("poke_mdr", mdr_out, m_mdr);
    model_step(1, 0, 9'h020, 0, lat, err, rdc, wrc, mdr);
    c = 2;
    wrc = 0;
    while (!done && c < 20) begin
      if (mem_wr_en) wrc++;
      @(negedge clock);
      c++;
    end
    chk("poke_lat", DW'(c), DW'(lat));
    chk("poke_wrcyc", DW'(wrc), 0);
    chk("poke_rdmdr", mdr_out, mdr);

    // Reset in the middle of a read wait.
    run_txn(1, 0, 9'h1F0, 0, o);
    model_step(1, 0, 9'h1F0, 0, lat, err, rdc, wrc, mdr);
    chk("pre_err", DW'(o.err), 1);
    @(negedge clock);
    bus_in = 32'h011;
    mar_in = 1'b1;
    @(negedge clock);
    mar_in = 1'b0;
    rd_req = 1'b1;
    @(negedge clock);
    rd_req = 1'b0;
    @(negedge clock);
    chk("mid_rden", DW'(mem_rd_en), 1);
    #1 reset = 1'b1;
    #1;
    chk("ar_rden", DW'(mem_rd_en), 0);
    chk("ar_wren", DW'(mem_wr_en), 0);
    chk("ar_busy", DW'(busy), 0);
    chk("ar_done", DW'(done), 0);
    chk("ar_err", DW'(addr_err), 0);
    chk("ar_mar", DW'(mar_out), 0);
    chk("ar_mdr", mdr_out, 0);
    @(negedge clock);
    reset = 1'b0;
    m_mdr = '0;
    m_err = 1'b0;
    run_txn(0, 1, 9'h030, 32'h600DCAFE, o);
    model_step(0, 1, 9'h030, 32'h600DCAFE, lat, err, rdc, wrc, mdr);
    cmp_obs("post_rst_wr", o, lat, err, rdc, wrc, mdr);
    run_txn(1, 0, 9'h030, 0, o);
    model_step(1, 0, 9'h030, 0, lat, err, rdc, wrc, mdr);
    cmp_obs("post_rst_rd", o, lat, err, rdc, wrc, mdr);

    // Random transactions.
    for (int i = 0; i < 40; i++) begin
      rd = $urandom_range(0, 1) == 1;
      wr = !rd || ($urandom_range(0, 3) == 0);
      a  = AW'($urandom_range(0, 300));
      d  = $urandom;
      run_txn(rd, wr, a, d, o);
      model_step(rd, wr, a, d, lat, err, rdc, wrc, mdr);
      cmp_obs($sformatf("rnd%0d", i), o, lat, err, rdc, wrc, mdr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory data word width.
REQ-002 SHALL have parameter ADDR_W, default 9, MAR and memory address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 512, number of valid words; MEM_DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter RD_LATENCY, default 1, legal range 1..7, read wait cycles before capture.
REQ-005 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port bus_in  input  DATA_W  value driven by the datapath bus.
REQ-008 SHALL have port mar_in  input  1  load MAR from bus_in[ADDR_W-1:0].
REQ-009 SHALL have port mdr_in  input  1  load MDR from bus_in.
REQ-010 SHALL have ports rd_req and wr_req  input  1 each  start a memory read or write.
REQ-011 SHALL have ports mar_out (ADDR_W) and mdr_out (DATA_W)  output  current MAR and MDR contents.
REQ-012 SHALL have ports busy, done and addr_err  output  1 each  transfer status.
REQ-013 SHALL have port mem_addr  output  ADDR_W  address to the RAM.
REQ-014 SHALL have port mem_wdata  output  DATA_W  write data to the RAM.
REQ-015 SHALL have ports mem_rd_en and mem_wr_en  output  1 each  RAM read and write enables.
REQ-016 SHALL have port mem_rdata  input  DATA_W  read data from the RAM.

Function
REQ-017 SHALL implement states IDLE, RD_WAIT, RD_CAP, WR and DONE.
REQ-018 SHALL drive mem_addr = MAR and mem_wdata = MDR continuously.
REQ-019 SHALL load MAR on mar_in only while busy = 0; mar_in while busy = 1 is ignored.
REQ-020 SHALL load MDR from bus_in on mdr_in only in IDLE with rd_req = 0; all other mdr_in pulses are ignored.
REQ-021 SHALL, in IDLE with rd_req = 1, give the read priority over a simultaneous wr_req, which is dropped.
REQ-022 SHALL, on an accepted request with MAR >= MEM_DEPTH, set addr_err, go directly to DONE and assert neither RAM enable.
REQ-023 SHALL, on an accepted in-range read, load the wait counter with RD_LATENCY-1 and go to RD_WAIT.
REQ-024 SHALL, in RD_WAIT, hold mem_rd_en = 1 and decrement the counter, going to RD_CAP in the cycle it equals 0.
REQ-025 SHALL, in RD_CAP, load MDR from mem_rdata and then go to DONE.
REQ-026 SHALL, on an accepted in-range write, go to WR, assert mem_wr_en for exactly one cycle, then go to DONE.
REQ-027 SHALL assert done for exactly one cycle in DONE and then return to IDLE.
REQ-028 SHALL assert busy in RD_WAIT, RD_CAP and WR only.
REQ-029 SHALL, for a read requested in cycle N, assert done in cycle N+RD_LATENCY+2 with MDR already valid.
REQ-030 SHALL, for a write requested in cycle N, assert done in cycle N+2.
REQ-031 SHALL ignore rd_req and wr_req in every state other than IDLE; requests are not queued.
REQ-032 SHALL keep addr_err set until the next accepted request, which clears it unless that request also faults.

Reset
REQ-033 SHALL, while reset = 1, force state IDLE, MAR = 0, MDR = 0, counter = 0, and busy, done, addr_err, mem_rd_en and mem_wr_en = 0, independent of clock.
REQ-034 SHALL, on reset during any transfer, abort it immediately with no further memory write and no MDR update.

Structure
REQ-035 SHALL take the state enumeration and the parameter defaults from the shared package mem_bus_pkg.
REQ-036 SHALL place the read wait counter in one sub-module, mem_wait_counter.

Verification
REQ-037 SHALL cover: MAR=0x010, MDR=0xDEADBEEF, wr_req -> mem_wr_en high for one cycle with mem_addr=0x010 and mem_wdata=0xDEADBEEF, done 2 cycles later.
REQ-038 SHALL cover: RD_LATENCY=3, RAM word 0x010=0x12345678, rd_req -> mem_rd_en high for 3 cycles, mdr_out=0x12345678 when done rises 5 cycles after the request.
REQ-039 SHALL cover: MEM_DEPTH=256, MAR=0x1F0, rd_req -> addr_err=1, no RAM enable, done after 1 cycle; a following in-range write clears addr_err.
REQ-040 SHALL cover: rd_req and wr_req in the same cycle -> only the read runs, and mem_wr_en stays 0 throughout.
REQ-041 SHALL cover: mar_in and mdr_in pulsed during RD_WAIT -> MAR unchanged, and MDR ends up holding the value read from the RAM.
REQ-042 SHALL cover: reset asserted in mid-RD_WAIT -> mem_rd_en falls without waiting for a clock edge, all outputs are 0, and the next wr_req works normally.
